// File: rtl/uart_inst_rx.sv
// UART receiver (8N1, LSB first) delivering calculator instruction bytes as one-cycle inst_vld strobes.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report parity mismatches on par_err.
module uart_inst_rx #(
  parameter int CLK_PER_BIT = 100,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] inst_wd,
  output logic       inst_vld,
  output logic       frm_err,
  output logic       par_err,
  output logic       busy
);

  localparam int            CW     = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] C_HALF = CW'(CLK_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic [2:0]             r_idx;
  logic [7:0]             r_shift;
  logic [7:0]             r_inst_wd;
  logic                   r_inst_vld;
  logic                   r_frm_err;
  logic                   w_rxs;
  logic                   w_tick;
  logic                   w_half;
  logic                   w_par_bad;
  logic                   w_stop_smp;
  logic                   w_vld;
  logic                   w_ferr;
  logic                   w_busy;

  assign w_rxs  = r_sync[SYNC_STAGES-1];
  assign w_tick = (r_cnt == C_LAST);
  assign w_half = (r_cnt == C_HALF);

  // Synchronizer resets to the idle (high) line level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (!w_rxs) w_state_next = S_START;
      S_START:  if (w_half) w_state_next = w_rxs ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
      S_DATA:   if (w_tick && (r_idx == 3'd7)) w_state_next = S_PARITY;
`else
      S_DATA:   if (w_tick && (r_idx == 3'd7)) w_state_next = S_STOP;
`endif
      S_PARITY: if (w_tick) w_state_next = S_STOP;
      S_STOP:   if (w_tick) w_state_next = w_rxs ? S_IDLE : S_BREAK;
      S_BREAK:  if (w_rxs) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // A low stop bit is reported as a framing error even when parity also mismatched.
  always_comb begin
    w_stop_smp = (r_state == S_STOP) && w_tick;
    w_vld      = w_stop_smp && w_rxs && !w_par_bad;
    w_ferr     = w_stop_smp && !w_rxs;
    w_busy     = (r_state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_idx      <= 3'd0;
      r_shift    <= 8'h00;
      r_inst_wd  <= 8'h00;
      r_inst_vld <= 1'b0;
      r_frm_err  <= 1'b0;
    end else begin
      if ((r_state != w_state_next) || (r_state == S_IDLE) || w_tick) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (r_state == S_START) begin
        r_idx <= 3'd0;
      end else if ((r_state == S_DATA) && w_tick) begin
        r_idx          <= r_idx + 3'd1;
        r_shift[r_idx] <= w_rxs;
      end
      r_inst_vld <= w_vld;
      r_frm_err  <= w_ferr;
      if (w_vld) begin
        r_inst_wd <= r_shift;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_bad;
  logic r_par_err;

  assign w_par_bad = r_par_bad;

  // Even parity: the received parity bit must equal the XOR of the data bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_par_bad <= 1'b0;
      r_par_err <= 1'b0;
    end else begin
      if ((r_state == S_PARITY) && w_tick) begin
        r_par_bad <= (w_rxs != ^r_shift);
      end
      r_par_err <= w_stop_smp && w_rxs && r_par_bad;
    end
  end

  assign par_err = r_par_err;
`else
  assign w_par_bad = 1'b0;
  assign par_err   = 1'b0;
`endif

  assign inst_wd  = r_inst_wd;
  assign inst_vld = r_inst_vld;
  assign frm_err  = r_frm_err;
  assign busy     = w_busy;

endmodule
